// File: rtl/cell_pos_mem_ctrl.sv
// rtl/cell_pos_mem_ctrl.sv - read/write sequencer and arbiter for one cell position RAM
// Optional count shadow: define CELL_POS_CTRL_COUNT_CACHE_EN
module cell_pos_mem_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    output logic                  rd_busy,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_done,
    output logic [ADDR_WIDTH-1:0] rd_count,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_last,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_done,
    output logic                  wr_overflow,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CNT_REQ  = 3'd1;
    localparam logic [2:0] S_CNT_WAIT = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_WR       = 3'd5;
    localparam logic [2:0] S_WR_CNT   = 3'd6;

    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    logic [2:0]            state;
    logic                  pending;
    logic                  cnt_wait_hold;
    logic                  zero_done;
    logic [1:0]            valid_sh;
    logic [1:0]            last_sh;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] q_cnt;
`ifdef CELL_POS_CTRL_COUNT_CACHE_EN
    logic                  cache_valid;
`endif

    // Only the low address-width bits of word 0 hold the count.
    assign q_cnt = (mem_q[ADDR_WIDTH-1:0] > MAX_CNT) ? MAX_CNT : mem_q[ADDR_WIDTH-1:0];

    assign wr_ready = (state == S_WR);
    assign rd_busy  = pending | (state inside {S_CNT_REQ, S_CNT_WAIT, S_STREAM, S_DRAIN});
    assign rd_valid = valid_sh[1];
    assign rd_last  = last_sh[1];
    assign rd_done  = last_sh[1] | zero_done;
    assign rd_data  = mem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            pending       <= 1'b0;
            cnt_wait_hold <= 1'b0;
            zero_done     <= 1'b0;
            valid_sh      <= '0;
            last_sh       <= '0;
            wr_cnt        <= '0;
            rd_count      <= '0;
            wr_done       <= 1'b0;
            wr_overflow   <= 1'b0;
            mem_address   <= '0;
            mem_data      <= '0;
            mem_rden      <= 1'b0;
            mem_wren      <= 1'b0;
`ifdef CELL_POS_CTRL_COUNT_CACHE_EN
            cache_valid   <= 1'b0;
`endif
        end else begin
            mem_rden  <= 1'b0;
            mem_wren  <= 1'b0;
            zero_done <= 1'b0;
            wr_done   <= 1'b0;
            // Two stages match the RAM read latency so flags line up with mem_q.
            valid_sh  <= {valid_sh[0], state == S_STREAM};
            last_sh   <= {last_sh[0], (state == S_STREAM) && (mem_address == rd_count)};
            if (rd_start) begin
                pending <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (wr_valid) begin
                        state  <= S_WR;
                        wr_cnt <= '0;
                    end else if (pending || rd_start) begin
                        pending <= 1'b0;
`ifdef CELL_POS_CTRL_COUNT_CACHE_EN
                        if (cache_valid) begin
                            if (rd_count == '0) begin
                                zero_done <= 1'b1;
                            end else begin
                                state       <= S_STREAM;
                                mem_address <= ADDR_WIDTH'(1);
                                mem_rden    <= 1'b1;
                            end
                        end else begin
                            state       <= S_CNT_REQ;
                            mem_address <= '0;
                            mem_rden    <= 1'b1;
                        end
`else
                        state       <= S_CNT_REQ;
                        mem_address <= '0;
                        mem_rden    <= 1'b1;
`endif
                    end
                end
                S_CNT_REQ: begin
                    state         <= S_CNT_WAIT;
                    cnt_wait_hold <= 1'b0;
                end
                S_CNT_WAIT: begin
                    if (!cnt_wait_hold) begin
                        cnt_wait_hold <= 1'b1;
                    end else begin
                        rd_count <= q_cnt;
`ifdef CELL_POS_CTRL_COUNT_CACHE_EN
                        cache_valid <= 1'b1;
`endif
                        if (q_cnt == '0) begin
                            zero_done <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state       <= S_STREAM;
                            mem_address <= ADDR_WIDTH'(1);
                            mem_rden    <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (mem_address == rd_count) begin
                        state <= S_DRAIN;
                    end else begin
                        mem_address <= mem_address + 1'b1;
                        mem_rden    <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (last_sh[1]) begin
                        state <= S_IDLE;
                    end
                end
                S_WR: begin
                    if (wr_valid) begin
                        mem_data <= wr_data;
                        if (wr_cnt < MAX_CNT) begin
                            mem_address <= wr_cnt + 1'b1;
                            mem_wren    <= 1'b1;
                            wr_cnt      <= wr_cnt + 1'b1;
                        end else begin
                            wr_overflow <= 1'b1;
                        end
                        if (wr_last) begin
                            state <= S_WR_CNT;
                        end
                    end
                end
                S_WR_CNT: begin
                    mem_address <= '0;
                    mem_data    <= DATA_WIDTH'(wr_cnt);
                    mem_wren    <= 1'b1;
                    wr_done     <= 1'b1;
                    rd_count    <= wr_cnt;
`ifdef CELL_POS_CTRL_COUNT_CACHE_EN
                    cache_valid <= 1'b1;
`endif
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_pos_mem_ctrl.sv
// tb/tb_cell_pos_mem_ctrl.sv - directed self-checking bench for cell_pos_mem_ctrl
module tb_cell_pos_mem_ctrl;
    localparam int DW = 96;
    localparam int PN = 4;
    localparam int AW = 8;
`ifdef CELL_POS_CTRL_COUNT_CACHE_EN
    localparam int CACHE = 1;
`else
    localparam int CACHE = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_start = 1'b0;
    logic          rd_busy, rd_valid, rd_last, rd_done;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_count;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          wr_last = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_done, wr_overflow;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_rden, mem_wren;
    logic [DW-1:0] mem_q = '0;

    always #5 clk = ~clk;

    cell_pos_mem_ctrl #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .rd_start(rd_start), .rd_busy(rd_busy), .rd_valid(rd_valid),
        .rd_last(rd_last), .rd_data(rd_data), .rd_done(rd_done), .rd_count(rd_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_last(wr_last), .wr_data(wr_data),
        .wr_done(wr_done), .wr_overflow(wr_overflow), .mem_address(mem_address),
        .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    // RAM model: 2-cycle read latency, plus a bench-side preload port
    logic [DW-1:0] ram [256];
    logic [DW-1:0] q1 = '0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) q1 <= ram[mem_address];
        mem_q <= q1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            rd_cyc[$];
    logic [AW-1:0] rd_adr[$];
    int            wr_cyc[$];
    logic [AW-1:0] wr_adr[$];
    logic [DW-1:0] wr_dat[$];
    int            v_cyc[$];
    logic [DW-1:0] v_dat[$];
    int last_cyc = -1, done_cyc = -1, wdone_cyc = -1;
    int done_n = 0, wdone_n = 0, excl_err = 0;

    always @(negedge clk) begin
        if (mem_rden) begin rd_cyc.push_back(cyc); rd_adr.push_back(mem_address); end
        if (mem_wren) begin wr_cyc.push_back(cyc); wr_adr.push_back(mem_address); wr_dat.push_back(mem_data); end
        if (rd_valid) begin v_cyc.push_back(cyc); v_dat.push_back(rd_data); end
        if (rd_valid && rd_last) last_cyc = cyc;
        if (rd_done) begin done_n++; done_cyc = cyc; end
        if (wr_done) begin wdone_n++; wdone_cyc = cyc; end
        if (mem_rden && mem_wren) excl_err++;
    end

    int checks = 0, errors = 0;
    logic busy_all;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = AW'(a); pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic clear_logs();
        rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
        v_cyc.delete(); v_dat.delete();
        last_cyc = -1; done_cyc = -1; wdone_cyc = -1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; rd_start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_done();
        int s;
        s = done_n;
        busy_all = 1'b1;
        for (int i = 0; i < 60 && done_n == s; i++) begin
            busy_all &= rd_busy;
            tick();
        end
        check("rd_done_seen", done_n != s, 1);
        tick();
    endtask

    task automatic do_read(output int t);
        clear_logs();
        t = cyc;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        wait_done();
    endtask

    task automatic do_batch(input int n, input logic [DW-1:0] base, output int acc_last);
        int guard, s;
        s = wdone_n;
        acc_last = -1;
        for (int k = 0; k < n; k++) begin
            wr_valid = 1'b1; wr_data = base + DW'(k); wr_last = (k == n - 1);
            guard = 0;
            while (!wr_ready && guard < 20) begin tick(); guard++; end
            check("wr_ready_seen", guard < 20, 1);
            acc_last = cyc;
            tick();
        end
        wr_valid = 1'b0; wr_last = 1'b0;
        for (int i = 0; i < 20 && wdone_n == s; i++) tick();
        check("wr_done_seen", wdone_n != s, 1);
        tick();
    endtask

    localparam logic [DW-1:0] P0 = 96'h0000_0003_0000_0002_0000_0001;
    localparam logic [DW-1:0] WB = 96'hA000_0000_B000_0000_C000_0000;
    localparam logic [DW-1:0] UP = 96'hDEAD_BEEF_0000_0000_0000_0002;

    initial begin
        int t, c;
        reset_dut();
        check("reset_flags", {rd_busy, rd_valid, rd_last, rd_done, wr_ready, wr_done, wr_overflow, mem_rden, mem_wren}, 0);
        check("reset_addr", mem_address, 0);
        check("reset_count", rd_count, 0);

        // count = 3 read timing
        preload(0, 3); preload(1, P0); preload(2, P0 + 1); preload(3, P0 + 2);
        do_read(t);
        check("t1_nrden", rd_cyc.size(), 4);
        check("t1_cnt_req_cyc", rd_cyc[0], t + 1);
        check("t1_cnt_req_adr", rd_adr[0], 0);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t1_issue_cyc%0d", i), rd_cyc[i], t + 3 + i);
            check($sformatf("t1_issue_adr%0d", i), rd_adr[i], i);
        end
        check("t1_nvalid", v_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_valid_cyc%0d", i), v_cyc[i], t + 6 + i);
            check($sformatf("t1_data%0d", i), v_dat[i], P0 + DW'(i));
        end
        check("t1_last_cyc", last_cyc, t + 8);
        check("t1_done_cyc", done_cyc, t + 8);
        check("t1_count", rd_count, 3);
        check("t1_busy_after", rd_busy, 0);

        // count = 0
        reset_dut();
        preload(0, 0);
        do_read(t);
        check("t2_done_cyc", done_cyc, t + 4);
        check("t2_nvalid", v_cyc.size(), 0);
        check("t2_count", rd_count, 0);

        // count word with high bits set
        reset_dut();
        preload(0, UP);
        do_read(t);
        check("t2b_count", rd_count, 2);
        check("t2b_nvalid", v_cyc.size(), 2);

        // two-beat batch then read back
        reset_dut();
        clear_logs();
        do_batch(2, WB, c);
        check("t3_nwr", wr_cyc.size(), 3);
        check("t3_adr0", wr_adr[0], 1);
        check("t3_dat0", wr_dat[0], WB);
        check("t3_adr1", wr_adr[1], 2);
        check("t3_dat1", wr_dat[1], WB + 1);
        check("t3_cnt_adr", wr_adr[2], 0);
        check("t3_cnt_dat", wr_dat[2], 2);
        check("t3_cnt_cyc", wr_cyc[2], c + 2);
        check("t3_wdone_cyc", wdone_cyc, c + 2);
        check("t3_count_wr", rd_count, 2);
        check("t3_ovf", wr_overflow, 0);
        do_read(t);
        check("t3_nvalid", v_cyc.size(), 2);
        check("t3_rd0", v_dat[0], WB);
        check("t3_rd1", v_dat[1], WB + 1);

        // simultaneous rd_start and wr_valid: batch first
        reset_dut();
        clear_logs();
        t = cyc;
        rd_start = 1'b1; wr_valid = 1'b1; wr_last = 1'b1; wr_data = WB + 7;
        tick();
        rd_start = 1'b0;
        check("t4_wr_ready", wr_ready, 1);
        check("t4_busy_t1", rd_busy, 1);
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
        wait_done();
        check("t4_busy_all", busy_all, 1);
        check("t4_wdone_cyc", wdone_cyc, t + 3);
        check("t4_first_rd_cyc", rd_cyc[0], t + 4);
        check("t4_first_rd_adr", rd_adr[0], CACHE != 0 ? 1 : 0);
        check("t4_nvalid", v_cyc.size(), 1);
        check("t4_rd0", v_dat[0], WB + 7);
        check("t4_count", rd_count, 1);

        // overflow: 5 beats into a 3-particle cell
        reset_dut();
        clear_logs();
        do_batch(5, WB + 16, c);
        check("t5_nwr", wr_cyc.size(), 4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5_adr%0d", i), wr_adr[i], i + 1);
            check($sformatf("t5_dat%0d", i), wr_dat[i], WB + 16 + DW'(i));
        end
        check("t5_cnt_adr", wr_adr[3], 0);
        check("t5_cnt_dat", wr_dat[3], 3);
        check("t5_ovf", wr_overflow, 1);
        do_read(t);
        check("t5_nvalid", v_cyc.size(), 3);
        check("t5_rd2", v_dat[2], WB + 18);
        check("t5_ovf_sticky", wr_overflow, 1);
        reset_dut();
        check("t5_ovf_cleared", wr_overflow, 0);

        // reset in the middle of STREAM
        preload(0, 3); preload(1, P0); preload(2, P0 + 1); preload(3, P0 + 2);
        clear_logs();
        t = cyc;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("t6_rst_flags", {rd_busy, rd_valid, rd_last, rd_done, wr_ready, wr_done, wr_overflow, mem_rden, mem_wren}, 0);
        check("t6_rst_addr", mem_address, 0);
        check("t6_rst_count", rd_count, 0);
        rst = 1'b0;
        tick();
        do_read(t);
        check("t6_first_valid", v_cyc[0], t + 6);
        check("t6_done_cyc", done_cyc, t + 8);
        check("t6_count", rd_count, 3);

        // second read of the same cell (count shadow when enabled)
        do_read(t);
        check("t7_nvalid", v_cyc.size(), 3);
        check("t7_first_valid", v_cyc[0], t + (CACHE != 0 ? 3 : 6));
        check("t7_done_cyc", done_cyc, t + (CACHE != 0 ? 5 : 8));
        check("t7_rd0", v_dat[0], P0);

        check("rden_wren_excl", excl_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
